// File: rtl/piano_key_encoder.sv
// piano_key_encoder: synchronises, debounces and arbitrates 7 note buttons into a
// registered one-hot note select with a new-note strobe, and toggles an octave flag
// on each debounced octave-button press. Latency: input change to sel = DEBOUNCE_CYC+2 edges.
module piano_key_encoder #(
  parameter int DEBOUNCE_CYC = 20000,
  parameter int CNT_W        = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] key_in,
  input  logic       oct_btn,
  output logic [6:0] sel,
  output logic       octave,
  output logic       key_strobe
);

  // Inputs 6..0 are the note keys, input 7 is the octave button.
  localparam int NIN = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [NIN-1:0]   sync1_q;
  logic [NIN-1:0]   sync2_q;
  logic [NIN-1:0]   stable_q;
  logic [NIN-1:0]   stable_d;
  logic [CNT_W-1:0] cnt_q [NIN];
  logic [CNT_W-1:0] cnt_d [NIN];

  logic             oct_prev_q;
  logic             octave_q;
  logic             octave_d;

  logic [0:0]       state_q;
  logic [0:0]       state_d;
  logic [6:0]       sel_q;
  logic [6:0]       sel_d;
  logic             strobe_q;
  logic             strobe_d;
  logic [6:0]       pick;

  // Two-flop synchronisers for all raw button inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {oct_btn, key_in};
      sync2_q <= sync1_q;
    end
  end

  // Per-input debounce: a change is accepted only after DEBOUNCE_CYC consecutive
  // cycles of disagreement; any agreement restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NIN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounce counters and stable bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_q <= '0;
      for (int i = 0; i < NIN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < NIN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Priority pick: the highest-numbered stable note key (C) wins.
  always_comb begin
    pick = '0;
    for (int i = 0; i < 7; i++) begin
      if (stable_q[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
      end
    end
  end

  // Note FSM: IDLE grabs one key, HOLD keeps it until that key is released.
  // Leaving HOLD always passes through one sel=0 cycle before a re-pick.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    strobe_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sel_d = '0;
        if (|stable_q[6:0]) begin
          sel_d    = pick;
          strobe_d = 1'b1;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if ((stable_q[6:0] & sel_q) == 7'd0) begin
          sel_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        sel_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Octave flag toggles once per debounced rising edge of the octave button.
  always_comb begin
    octave_d = octave_q ^ (stable_q[7] & ~oct_prev_q);
  end

  // FSM, note outputs and octave state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      strobe_q   <= 1'b0;
      oct_prev_q <= 1'b0;
      octave_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      strobe_q   <= strobe_d;
      oct_prev_q <= stable_q[7];
      octave_q   <= octave_d;
    end
  end

  assign sel        = sel_q;
  assign octave     = octave_q;
  assign key_strobe = strobe_q;

endmodule

// File: tb/tb_piano_key_encoder.sv
// Bench for piano_key_encoder: directed scenarios plus random key/octave traffic,
// checked by a scoreboard fed from a spec-level reference model.
module tb_piano_key_encoder;

  localparam int D = 4;

  localparam logic [6:0] K_C = 7'b1000000;
  localparam logic [6:0] K_D = 7'b0100000;
  localparam logic [6:0] K_E = 7'b0010000;
  localparam logic [6:0] K_A = 7'b0000010;
  localparam logic [6:0] K_B = 7'b0000001;

  logic       clk;
  logic       rst;
  logic [6:0] key_in;
  logic       oct_btn;
  logic [6:0] sel;
  logic       octave;
  logic       key_strobe;

  int n_checks;
  int n_fail;

  piano_key_encoder #(.DEBOUNCE_CYC(D), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .oct_btn    (oct_btn),
    .sel        (sel),
    .octave     (octave),
    .key_strobe (key_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  // Level accepted once the last D synchronised samples all disagree with it;
  // a synchronised sample at edge n is the raw value seen two edges earlier.
  typedef struct {
    int       cyc;
    bit [8:0] val;
  } exp_t;

  exp_t     exp_q[$];
  bit [7:0] hist[$];
  bit [7:0] m_stable;
  bit [7:0] n_stable;
  bit [6:0] m_sel;
  bit [6:0] n_sel;
  bit       m_oct;
  bit       n_oct;
  bit       m_prev;
  bit       m_strobe;
  bit       n_strobe;
  bit       all_diff;
  bit [7:0] smp;
  int       top;
  int       cyc;
  exp_t     ev;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist = {};
      for (int j = 0; j < D + 2; j++) hist.push_back(8'd0);
      m_stable = '0;
      m_sel    = '0;
      m_oct    = 1'b0;
      m_prev   = 1'b0;
      m_strobe = 1'b0;
      cyc      = 0;
      exp_q    = {};
    end else begin
      cyc++;
      n_stable = m_stable;
      for (int b = 0; b < 8; b++) begin
        all_diff = 1'b1;
        for (int j = 1; j <= D; j++) begin
          smp = hist[hist.size() - 1 - j];
          if (smp[b] == m_stable[b]) all_diff = 1'b0;
        end
        if (all_diff) n_stable[b] = ~m_stable[b];
      end
      if (m_sel != 7'd0) begin
        n_sel = ((m_stable[6:0] & m_sel) == 7'd0) ? 7'd0 : m_sel;
      end else if (m_stable[6:0] != 7'd0) begin
        top = 0;
        for (int i = 0; i < 7; i++) if (m_stable[i]) top = i;
        n_sel = 7'(1 << top);
      end else begin
        n_sel = 7'd0;
      end
      n_strobe = (m_sel == 7'd0) && (n_sel != 7'd0);
      n_oct    = m_oct ^ (m_stable[7] & ~m_prev);
      if ({n_sel, n_oct, n_strobe} != {m_sel, m_oct, m_strobe}) begin
        ev.cyc = cyc;
        ev.val = {n_sel, n_oct, n_strobe};
        exp_q.push_back(ev);
      end
      hist.push_back({oct_btn, key_in});
      void'(hist.pop_front());
      m_prev   = m_stable[7];
      m_stable = n_stable;
      m_sel    = n_sel;
      m_oct    = n_oct;
      m_strobe = n_strobe;
    end
  end

  // ---------------- monitor ----------------
  bit [8:0] last;
  bit [8:0] obs;
  bit       prev_strobe;
  exp_t     got;

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      last        = '0;
      prev_strobe = 1'b0;
    end else begin
      obs = {sel, octave, key_strobe};
      chk("sel_onehot0", ($countones(sel) <= 1) ? 1 : 0, 1);
      chk("strobe_not_back_to_back", (key_strobe && prev_strobe) ? 1 : 0, 0);
      prev_strobe = key_strobe;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        got = exp_q.pop_front();
        chk("missed_output_event_cycle", cyc, got.cyc);
      end
      if (obs != last) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output_change", int'(obs), int'(last));
        end else begin
          got = exp_q.pop_front();
          chk("event_cycle", cyc, got.cyc);
          chk("event_sel_oct_strobe", int'(obs), int'(got.val));
        end
        last = obs;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [6:0] k, input logic o, input int n);
    key_in  = k;
    oct_btn = o;
    repeat (n) @(negedge clk);
  endtask

  // Edges from the first sampling edge until sel==v (-1 on timeout).
  task automatic wait_sel(input logic [6:0] v, output int lat);
    lat = -1;
    for (int e = 0; e < 40; e++) begin
      @(negedge clk);
      if (sel == v) begin
        lat = e;
        break;
      end
    end
  endtask

  int lat;
  int nstrb;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    key_in   = '0;
    oct_btn  = 1'b0;
    rst      = 1'b1;
    #1 rst   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_sel", int'(sel), 0);
    chk("reset_octave", int'(octave), 0);
    chk("reset_strobe", int'(key_strobe), 0);
    rst = 1'b1;
    drive(7'd0, 1'b0, 2);

    // 1: press and release C
    key_in = K_C;
    wait_sel(K_C, lat);
    chk("s1_press_latency", lat, D + 2);
    chk("s1_strobe_first_cycle", int'(key_strobe), 1);
    @(negedge clk);
    chk("s1_strobe_drops", int'(key_strobe), 0);
    drive(K_C, 1'b0, 4);
    key_in = 7'd0;
    wait_sel(7'd0, lat);
    chk("s1_release_latency", lat, D + 2);
    drive(7'd0, 1'b0, 3);

    // 2: short pulse and bouncing key are rejected
    drive(K_E, 1'b0, 3);
    drive(K_D, 1'b0, 1);
    drive(7'd0, 1'b0, 1);
    drive(K_D, 1'b0, 1);
    key_in = 7'd0;
    nstrb = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (key_strobe || sel != 7'd0) nstrb++;
    end
    chk("s2_bounce_ignored", nstrb, 0);

    // 3: held key blocks others; release passes through one empty cycle
    key_in = K_D;
    wait_sel(K_D, lat);
    chk("s3_d_latency", lat, D + 2);
    drive(K_D | K_C, 1'b0, 10);
    chk("s3_d_kept_with_c", int'(sel), int'(K_D));
    key_in = K_C;
    wait_sel(7'd0, lat);
    chk("s3_release_latency", lat, D + 2);
    @(negedge clk);
    chk("s3_c_after_one_gap", int'(sel), int'(K_C));
    chk("s3_c_new_strobe", int'(key_strobe), 1);
    drive(7'd0, 1'b0, 12);

    // 4: simultaneous G and A -> G wins
    key_in = 7'b0000110;
    wait_sel(7'b0000100, lat);
    chk("s4_g_wins_latency", lat, D + 2);
    chk("s4_strobe", int'(key_strobe), 1);
    drive(7'b0000110, 1'b0, 5);
    drive(7'd0, 1'b0, 12);

    // 5: octave toggles once per press, independent of a held note
    key_in = K_B;
    wait_sel(K_B, lat);
    drive(K_B, 1'b1, 10);
    chk("s5_octave_high", int'(octave), 1);
    chk("s5_sel_kept", int'(sel), int'(K_B));
    drive(K_B, 1'b0, 10);
    chk("s5_octave_holds", int'(octave), 1);
    drive(K_B, 1'b1, 10);
    chk("s5_octave_low", int'(octave), 0);
    chk("s5_sel_kept2", int'(sel), int'(K_B));
    drive(7'd0, 1'b0, 12);

    // 6: async reset mid-press, then re-acquire the held key
    drive(7'd0, 1'b1, 10);
    drive(7'd0, 1'b0, 8);
    chk("s6_octave_set", int'(octave), 1);
    key_in = K_A;
    wait_sel(K_A, lat);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("s6_async_sel", int'(sel), 0);
    chk("s6_async_octave", int'(octave), 0);
    chk("s6_async_strobe", int'(key_strobe), 0);
    #3 rst = 1'b1;
    wait_sel(K_A, lat);
    chk("s6_reacquire_latency", lat, D + 2);
    drive(K_A, 1'b0, 3);
    drive(7'd0, 1'b0, 12);

    // random traffic
    for (int it = 0; it < 300; it++) begin
      int r;
      logic [6:0] k;
      r = $urandom_range(0, 3);
      if (r == 0) k = 7'd0;
      else if (r == 1) k = 7'(1 << $urandom_range(0, 6));
      else k = 7'($urandom);
      drive(k, ($urandom_range(0, 3) == 0), $urandom_range(1, 12));
    end
    drive(7'd0, 1'b0, 30);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
